rom_access_arbiter: RTL

// Shares the single 128x16 instruction/constant ROM (enable, 7-bit address, 16-bit data) between two

---
 rtl/rom_access_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rom_access_arbiter.sv
// Two-port arbiter in front of a single combinational ROM: picks a requester, holds the ROM
// enable for WAIT_CYCLES cycles, captures the word and returns it with a one-cycle valid pulse.
module rom_access_arbiter #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rom_enable,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("rom_access_arbiter: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               last_grant, last_grant_n;
    logic               winner, winner_n;
    logic               first, first_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [DATA_W-1:0]  rdata0_q, rdata0_n;
    logic [DATA_W-1:0]  rdata1_q, rdata1_n;
    logic               w;

    // A tie goes to port 0 under fixed priority, otherwise to the port not served last.
    function automatic logic pick(input logic r0, input logic r1, input logic lg);
        if (r0 && !r1)
            return 1'b0;
        else if (r1 && !r0)
            return 1'b1;
        else if (FIXED_PRIO != 0)
            return 1'b0;
        else
            return ~lg;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            first      <= 1'b0;
            addr_q     <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            winner     <= winner_n;
            first      <= first_n;
            addr_q     <= addr_n;
            rdata0_q   <= rdata0_n;
            rdata1_q   <= rdata1_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        winner_n     = winner;
        first_n      = 1'b0;
        addr_n       = addr_q;
        rdata0_n     = rdata0_q;
        rdata1_n     = rdata1_q;
        w            = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (req0 || req1) begin
                    w            = pick(req0, req1, last_grant);
                    state_n      = ACCESS;
                    winner_n     = w;
                    last_grant_n = w;
                    addr_n       = w ? addr1 : addr0;
                    cnt_n        = CNT_W'(WAIT_CYCLES - 1);
                    first_n      = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    if (winner)
                        rdata1_n = rom_data;
                    else
                        rdata0_n = rom_data;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // first is only ever set on entry to ACCESS, so it marks the grant cycle.
    assign rom_enable  = (state == ACCESS);
    assign gnt0        = first & ~winner;
    assign gnt1        = first & winner;
    assign rvalid0     = (state == DONE) & ~winner;
    assign rvalid1     = (state == DONE) & winner;
    assign busy        = (state != IDLE);
    assign rom_address = addr_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;

endmodule
